ss_sgw: RTL and testbench

//  Scatter-gather writer: the destination-side counterpart of the SG reader. Takes a command from ss_adma,

---
 rtl/ss_sg_pkg.sv | 43 ++++
 rtl/ss_sgw_if.sv | 26 ++
 rtl/ss_sgw.sv | 230 +++++++++++++++++++++++
 tb/tb_ss_sgw.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ss_sg_pkg.sv
// Shared definitions for the scatter-gather reader/writer pair: state codes,
// descriptor field positions and descriptor decode helpers.
package ss_sg_pkg;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_CMD    = 4'd1,
      S_NEXT   = 4'd2,
      S_D_REQ  = 4'd3,
      S_B_WAIT = 4'd4,
      S_B_REQ  = 4'd5,
      S_D_WB   = 4'd6,
      S_END    = 4'd7,
      S_PANIC  = 4'd8
   } sg_state_e;

   localparam int DESC_ADDR_HI  = 31;
   localparam int DESC_ADDR_LO  = 3;
   localparam int DESC_LEN_HI   = 18;
   localparam int DESC_LEN_LO   = 3;
   localparam int DESC_LAST_BIT = 20;
   localparam int DESC_NEXT_HI  = 31;
   localparam int DESC_NEXT_LO  = 3;

   typedef struct packed {
      logic [28:0] addr;
      logic [15:0] len;
      logic        last;
   } desc_t;

   function automatic desc_t decode_desc(input logic [31:0] lo, input logic [31:0] hi);
      desc_t d;
      d.addr = lo[DESC_ADDR_HI:DESC_ADDR_LO];
      d.len  = hi[DESC_LEN_HI:DESC_LEN_LO];
      d.last = hi[DESC_LAST_BIT];
      return d;
   endfunction

   function automatic logic [28:0] decode_next(input logic [31:0] hi);
      return hi[DESC_NEXT_HI:DESC_NEXT_LO];
   endfunction

endpackage

// File: rtl/ss_sgw_if.sv
// 64-bit Wishbone bus between the SG writer (master) and the memory side (slave).
interface ss_sgw_if;
   logic        wbs_cyc;
   logic        wbs_stb;
   logic        wbs_we;
   logic        wbs_cab;
   logic [3:0]  wbs_sel;
   logic [31:0] wbs_adr;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_dat64_i;
   logic [31:0] wbs_dat_o;
   logic [31:0] wbs_dat64_o;
   logic        wbs_ack;
   logic        wbs_rty;
   logic        wbs_err;

   modport master (
      output wbs_cyc, wbs_stb, wbs_we, wbs_cab, wbs_sel, wbs_adr, wbs_dat_i, wbs_dat64_i,
      input  wbs_dat_o, wbs_dat64_o, wbs_ack, wbs_rty, wbs_err
   );

   modport slave (
      input  wbs_cyc, wbs_stb, wbs_we, wbs_cab, wbs_sel, wbs_adr, wbs_dat_i, wbs_dat64_i,
      output wbs_dat_o, wbs_dat64_o, wbs_ack, wbs_rty, wbs_err
   );
endinterface

// File: rtl/ss_sgw.sv
// Scatter-gather writer: walks a destination descriptor chain and drains the
// adma FIFO into each buffer, optionally marking descriptors done.
module ss_sgw
   import ss_sg_pkg::*;
#(
   parameter bit WRITEBACK = 1'b1,
   parameter int DONE_BIT  = 31
) (
   input  logic         wb_clk_i,
   input  logic         wb_rst_i,
   ss_sgw_if.master     wbs,
   input  logic [31:0]  ss_dat,
   input  logic         ss_we,
   input  logic [1:0]   ss_adr,
   input  logic         ss_done,
   input  logic         ss_ready,
   input  logic [63:0]  fifo_dat,
   output logic         ss_xfer,
   output logic [7:0]   sg_state,
   output logic [15:0]  sg_desc,
   output logic [28:0]  sg_addr,
   output logic [28:0]  sg_next,
   output logic [3:0]   sg_err
);

   typedef struct packed {
      sg_state_e   state;
      logic        cyc;
      logic        stb;
      logic        we;
      logic        cab;
      logic [3:0]  sel;
      logic [28:0] adr;
      logic [31:0] dat_lo;
      logic [31:0] dat_hi;
      logic        beat;
      logic [23:0] dc_fc;
      logic [28:0] next;
      logic [28:0] addr;
      logic [15:0] len;
      logic        last;
      logic [28:0] desc_ptr;
      logic [31:0] desc_lo;
      logic [31:0] desc_hi;
      logic [3:0]  err;
   } regs_t;

   regs_t r_r;
   regs_t r_s;
   logic  xfer_s;
   desc_t dsc_s;

   function automatic regs_t bus_idle(input regs_t r);
      regs_t q = r;
      q.cyc = 1'b0;
      q.stb = 1'b0;
      q.we  = 1'b0;
      q.cab = 1'b0;
      q.sel = 4'h0;
      return q;
   endfunction

   // Error code records the bus state in which the error was seen.
   function automatic regs_t to_panic(input regs_t r);
      regs_t q = bus_idle(r);
      q.err   = r.state;
      q.state = S_PANIC;
      return q;
   endfunction

   // State and all bus-facing registers.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         r_r <= '0;
      end else begin
         r_r <= r_s;
      end
   end

   // Next-state and next-register computation.
   always_comb begin
      r_s    = r_r;
      xfer_s = 1'b0;
      dsc_s  = decode_desc(wbs.wbs_dat_o, wbs.wbs_dat64_o);
      case (r_r.state)
         S_IDLE: begin
            if (ss_we) r_s.state = S_CMD;
            else       r_s.state = S_IDLE;
         end
         S_CMD: begin
            if (ss_we) begin
               case (ss_adr)
                  2'd1: r_s.dc_fc = ss_dat[23:0];
                  2'd2: r_s.next  = ss_dat[31:3];
                  2'd3: begin
                     r_s.last  = 1'b0;
                     r_s.state = S_NEXT;
                  end
                  default: r_s.state = S_CMD;
               endcase
            end else begin
               r_s.state = S_CMD;
            end
         end
         S_NEXT: begin
            if (r_r.last || r_r.dc_fc == 24'd0) begin
               r_s.state = S_END;
            end else begin
               r_s.cyc      = 1'b1;
               r_s.stb      = 1'b1;
               r_s.cab      = 1'b1;
               r_s.we       = 1'b0;
               r_s.sel      = 4'h0;
               r_s.adr      = r_r.next;
               r_s.beat     = 1'b0;
               r_s.desc_ptr = r_r.next;
               r_s.state    = S_D_REQ;
            end
         end
         S_D_REQ: begin
            // rty leaves the burst request untouched so it is re-issued.
            if (wbs.wbs_err) begin
               r_s = to_panic(r_r);
            end else if (wbs.wbs_ack && !r_r.beat) begin
               r_s.len     = dsc_s.len;
               r_s.last    = dsc_s.last;
               r_s.addr    = dsc_s.addr;
               r_s.desc_lo = wbs.wbs_dat_o;
               r_s.desc_hi = wbs.wbs_dat64_o;
               r_s.beat    = 1'b1;
               r_s.adr     = r_r.desc_ptr + 29'd1;
            end else if (wbs.wbs_ack) begin
               r_s      = bus_idle(r_r);
               r_s.next = decode_next(wbs.wbs_dat64_o);
               if (r_r.len == 16'd0) r_s.state = WRITEBACK ? S_D_WB : S_NEXT;
               else                  r_s.state = S_B_WAIT;
            end else begin
               r_s.state = S_D_REQ;
            end
         end
         S_B_WAIT: begin
            if (ss_ready) begin
               r_s.cyc    = 1'b1;
               r_s.stb    = 1'b1;
               r_s.we     = 1'b1;
               r_s.cab    = 1'b0;
               r_s.sel    = 4'hf;
               r_s.dat_lo = fifo_dat[31:0];
               r_s.dat_hi = fifo_dat[63:32];
               r_s.adr    = r_r.addr;
               r_s.state  = S_B_REQ;
            end else begin
               r_s = bus_idle(r_r);
            end
         end
         S_B_REQ: begin
            if (wbs.wbs_err) begin
               r_s = to_panic(r_r);
            end else if (wbs.wbs_ack) begin
               xfer_s    = 1'b1;
               r_s.addr  = r_r.addr + 29'd1;
               r_s.len   = r_r.len - 16'd1;
               r_s.dc_fc = r_r.dc_fc - 24'd1;
               r_s.stb   = 1'b0;
               if (r_r.len == 16'd1 || r_r.dc_fc == 24'd1) begin
                  r_s       = bus_idle(r_s);
                  r_s.last  = r_r.last | (r_r.dc_fc == 24'd1);
                  r_s.state = WRITEBACK ? S_D_WB : S_NEXT;
               end else begin
                  r_s.state = S_B_WAIT;
               end
            end else if (wbs.wbs_rty) begin
               r_s       = bus_idle(r_r);
               r_s.state = S_B_WAIT;
            end else begin
               r_s.state = S_B_REQ;
            end
         end
         S_D_WB: begin
            // Entered with the bus released; the first cycle issues the write.
            if (!r_r.cyc) begin
               r_s.cyc    = 1'b1;
               r_s.stb    = 1'b1;
               r_s.we     = 1'b1;
               r_s.cab    = 1'b0;
               r_s.sel    = 4'hf;
               r_s.adr    = r_r.desc_ptr;
               r_s.dat_lo = r_r.desc_lo;
               r_s.dat_hi = r_r.desc_hi | (32'd1 << DONE_BIT);
            end else if (wbs.wbs_err) begin
               r_s = to_panic(r_r);
            end else if (wbs.wbs_ack) begin
               r_s       = bus_idle(r_r);
               r_s.state = S_NEXT;
            end else begin
               r_s.state = S_D_WB;
            end
         end
         S_END: begin
            if (ss_done) r_s.state = S_IDLE;
            else         r_s.state = S_END;
         end
         S_PANIC: begin
            r_s.state = S_PANIC;
         end
         default: begin
            r_s       = bus_idle(r_r);
            r_s.state = S_IDLE;
         end
      endcase
   end

   assign wbs.wbs_cyc     = r_r.cyc;
   assign wbs.wbs_stb     = r_r.stb;
   assign wbs.wbs_we      = r_r.we;
   assign wbs.wbs_cab     = r_r.cab;
   assign wbs.wbs_sel     = r_r.sel;
   assign wbs.wbs_adr     = {r_r.adr, 3'b000};
   assign wbs.wbs_dat_i   = r_r.dat_lo;
   assign wbs.wbs_dat64_i = r_r.dat_hi;

   // The pop is qualified by reset so an ack landing in a reset cycle is not consumed.
   assign ss_xfer  = xfer_s & wb_rst_i;
   assign sg_state = {r_r.last, 3'b000, r_r.state};
   assign sg_desc  = r_r.len;
   assign sg_addr  = r_r.addr;
   assign sg_next  = r_r.next;
   assign sg_err   = r_r.err;

endmodule

// File: tb/tb_ss_sgw.sv
// Bench for ss_sgw: memory/FIFO models, table-driven chains, corner sequences
// and randomized chains checked against a descriptor-walk reference model.
module tb_ss_sgw;
   import ss_sg_pkg::*;

   logic        wb_clk_i;
   logic        wb_rst_i;
   logic [31:0] ss_dat;
   logic        ss_we;
   logic [1:0]  ss_adr;
   logic        ss_done;
   logic        ss_ready;
   logic [63:0] fifo_dat;
   logic        ss_xfer;
   logic [7:0]  sg_state;
   logic [15:0] sg_desc;
   logic [28:0] sg_addr;
   logic [28:0] sg_next;
   logic [3:0]  sg_err;

   ss_sgw_if bus ();

   ss_sgw #(.WRITEBACK(1'b1), .DONE_BIT(31)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wbs(bus),
      .ss_dat(ss_dat), .ss_we(ss_we), .ss_adr(ss_adr), .ss_done(ss_done),
      .ss_ready(ss_ready), .fifo_dat(fifo_dat), .ss_xfer(ss_xfer),
      .sg_state(sg_state), .sg_desc(sg_desc), .sg_addr(sg_addr),
      .sg_next(sg_next), .sg_err(sg_err)
   );

   initial wb_clk_i = 1'b0;
   always #5 wb_clk_i = ~wb_clk_i;

   int checks = 0;
   int failures = 0;

   logic [63:0] mem [logic [28:0]];
   logic [63:0] fifo_q [$];
   logic [28:0] log_adr [$];
   logic [63:0] log_dat [$];
   logic [28:0] exp_adr [$];
   logic [63:0] exp_dat [$];
   int xfer_cnt, dbl_xfer, dwr_attempt, rty_at, rty_cnt;
   bit pop_pend, prev_xfer, ready_en, ready_rand, rand_rty, err_dreq;
   int m_beats, m_wbs;
   logic [15:0] m_len;
   logic [28:0] m_addr, m_next;
   logic m_last;
   logic [28:0] sa;

   // Memory slave and show-ahead FIFO; responses change on the falling edge.
   always @(negedge wb_clk_i) begin
      if (pop_pend) begin
         void'(fifo_q.pop_front());
         pop_pend = 1'b0;
      end
      if (ready_rand) ready_en = ($urandom_range(0, 1) == 1);
      ss_ready = ready_en && (fifo_q.size() > 0);
      fifo_dat = (fifo_q.size() > 0) ? fifo_q[0] : 64'h0;
      bus.wbs_ack = 1'b0; bus.wbs_rty = 1'b0; bus.wbs_err = 1'b0;
      bus.wbs_dat_o = 32'h0; bus.wbs_dat64_o = 32'h0;
      if (bus.wbs_cyc && bus.wbs_stb) begin
         sa = bus.wbs_adr[31:3];
         if (bus.wbs_we) begin
            dwr_attempt++;
            if (dwr_attempt == rty_at || (rand_rty && $urandom_range(0, 3) == 0)) begin
               bus.wbs_rty = 1'b1;
               rty_cnt++;
            end else begin
               bus.wbs_ack = 1'b1;
               mem[sa] = {bus.wbs_dat64_i, bus.wbs_dat_i};
               log_adr.push_back(sa);
               log_dat.push_back({bus.wbs_dat64_i, bus.wbs_dat_i});
            end
         end else if (err_dreq) begin
            bus.wbs_err = 1'b1;
         end else begin
            bus.wbs_ack = 1'b1;
            {bus.wbs_dat64_o, bus.wbs_dat_o} = mem.exists(sa) ? mem[sa] : 64'h0;
         end
      end
      #1;
      if (ss_xfer) begin
         xfer_cnt++;
         pop_pend = 1'b1;
         if (prev_xfer) dbl_xfer++;
      end
      prev_xfer = ss_xfer;
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic put_desc(input logic [28:0] p, input logic [28:0] buf_a, input logic [15:0] len,
                           input logic last, input logic [28:0] nxt);
      logic [31:0] hi = 32'h0;
      hi[18:3] = len;
      hi[20]   = last;
      mem[p]         = {hi, buf_a, 3'b000};
      mem[p + 29'd1] = {nxt, 3'b000, 32'h0};
   endtask

   function automatic logic [63:0] rd(input logic [28:0] a);
      return mem.exists(a) ? mem[a] : 64'h0;
   endfunction

   // Walk the chain as described: fill each buffer from the FIFO until the
   // word budget runs out, mark the descriptor done, follow next.
   task automatic model_run(input logic [28:0] start, input int dcfc);
      logic [28:0] ptr = start;
      int rem = dcfc;
      bit last = 1'b0;
      int k = 0;
      logic [63:0] d0, d1;
      int len;
      logic [28:0] a;
      exp_adr.delete(); exp_dat.delete();
      m_beats = 0; m_wbs = 0;
      while (!last && rem > 0) begin
         d0 = rd(ptr);
         d1 = rd(ptr + 29'd1);
         len = int'(d0[50:35]);
         last = d0[52];
         a = d0[31:3];
         while (len > 0 && rem > 0) begin
            exp_adr.push_back(a); exp_dat.push_back(fifo_q[k]);
            k++; a++; len--; rem--; m_beats++;
         end
         if (rem == 0) last = 1'b1;
         exp_adr.push_back(ptr); exp_dat.push_back(d0 | (64'd1 << 63));
         m_wbs++;
         m_next = d1[63:35];
         m_len = 16'(len);
         m_addr = a;
         ptr = m_next;
      end
      m_last = last;
   endtask

   task automatic cmd(input logic [1:0] a, input logic [31:0] d);
      @(negedge wb_clk_i);
      ss_we = 1'b1; ss_adr = a; ss_dat = d;
      @(negedge wb_clk_i);
      ss_we = 1'b0;
   endtask

   task automatic start_job(input logic [28:0] start, input int dcfc);
      fifo_q.delete();
      pop_pend = 1'b0;
      for (int i = 0; i < 48; i++) fifo_q.push_back({$urandom, $urandom});
      model_run(start, dcfc);
      log_adr.delete(); log_dat.delete();
      xfer_cnt = 0; dbl_xfer = 0; dwr_attempt = 0; rty_cnt = 0;
      cmd(2'd0, 32'h0);
      cmd(2'd1, 32'(dcfc));
      cmd(2'd2, {start, 3'b000});
      cmd(2'd3, 32'h0);
   endtask

   task automatic wait_state(input string nm, input logic [3:0] st);
      int n = 0;
      while (sg_state[3:0] != S_END && sg_state[3:0] != S_PANIC && n < 3000) begin
         @(negedge wb_clk_i);
         n++;
      end
      #2;
      chk({nm, " final state"}, sg_state[3:0], st);
   endtask

   task automatic check_job(input string nm, input int beats, input int wbs, input logic [15:0] desc,
                            input logic last);
      int bad = 0;
      chk({nm, " beats"}, xfer_cnt, beats);
      chk({nm, " writes"}, log_adr.size(), beats + wbs);
      chk({nm, " sg_desc"}, sg_desc, desc);
      chk({nm, " sg_last"}, sg_state[7], last);
      chk({nm, " sg_addr"}, sg_addr, m_addr);
      chk({nm, " sg_next"}, sg_next, m_next);
      chk({nm, " b2b xfer"}, dbl_xfer, 0);
      if (log_adr.size() != exp_adr.size()) bad = 1;
      else for (int i = 0; i < exp_adr.size(); i++)
         if (log_adr[i] !== exp_adr[i] || log_dat[i] !== exp_dat[i]) bad = 1;
      chk({nm, " write log"}, bad, 0);
      @(negedge wb_clk_i);
      ss_done = 1'b1;
      @(negedge wb_clk_i);
      ss_done = 1'b0;
      #2;
      chk({nm, " back to idle"}, sg_state[3:0], S_IDLE);
   endtask

   typedef struct {
      logic [28:0] base0;
      logic [15:0] len0;
      logic        last0;
      logic [15:0] len1;
      int          dcfc;
      int          exp_beats;
      int          exp_wbs;
      logic [15:0] exp_desc;
      logic        exp_last;
   } vec_t;
   vec_t vecs [7];

   logic outs_or;
   int   saved, n;

   initial begin
      vecs[0] = '{29'h1000,     16'd4, 1'b1, 16'd2, 100, 4, 1, 16'd0, 1'b1};
      vecs[1] = '{29'h1000,     16'd2, 1'b0, 16'd3, 100, 5, 2, 16'd0, 1'b1};
      vecs[2] = '{29'h1000,     16'd8, 1'b1, 16'd2, 3,   3, 1, 16'd5, 1'b1};
      vecs[3] = '{29'h1000,     16'd0, 1'b0, 16'd2, 10,  2, 2, 16'd0, 1'b1};
      vecs[4] = '{29'h1000,     16'd3, 1'b0, 16'd5, 3,   3, 1, 16'd0, 1'b1};
      vecs[5] = '{29'h1000,     16'd2, 1'b0, 16'd4, 4,   4, 2, 16'd2, 1'b1};
      vecs[6] = '{29'h1FFFFFFE, 16'd4, 1'b1, 16'd1, 100, 4, 1, 16'd0, 1'b1};

      wb_rst_i = 1'b0; ss_dat = 32'h0; ss_we = 1'b0; ss_adr = 2'd0; ss_done = 1'b0;
      ss_ready = 1'b0; fifo_dat = 64'h0;
      bus.wbs_ack = 1'b0; bus.wbs_rty = 1'b0; bus.wbs_err = 1'b0;
      bus.wbs_dat_o = 32'h0; bus.wbs_dat64_o = 32'h0;
      ready_en = 1'b1; ready_rand = 1'b0; rand_rty = 1'b0; err_dreq = 1'b0; rty_at = -1;
      pop_pend = 1'b0; prev_xfer = 1'b0;

      repeat (3) @(negedge wb_clk_i);
      #2;
      chk("reset state", sg_state, 0);
      outs_or = |{bus.wbs_cyc, bus.wbs_stb, bus.wbs_we, bus.wbs_cab, bus.wbs_sel, bus.wbs_adr,
                  bus.wbs_dat_i, bus.wbs_dat64_i, ss_xfer, sg_desc, sg_addr, sg_next, sg_err};
      chk("reset outputs", outs_or, 0);
      wb_rst_i = 1'b1;

      for (int v = 0; v < 7; v++) begin
         mem.delete();
         put_desc(29'h100, vecs[v].base0, vecs[v].len0, vecs[v].last0, 29'h200);
         put_desc(29'h200, 29'h3000, vecs[v].len1, 1'b1, 29'h300);
         start_job(29'h100, vecs[v].dcfc);
         wait_state($sformatf("vec%0d", v), S_END);
         check_job($sformatf("vec%0d", v), vecs[v].exp_beats, vecs[v].exp_wbs,
                   vecs[v].exp_desc, vecs[v].exp_last);
      end

      // FIFO runs dry mid-buffer: bus must be released, data stays contiguous.
      mem.delete();
      put_desc(29'h100, 29'h7000, 16'd6, 1'b1, 29'h0);
      start_job(29'h100, 100);
      n = 0;
      while (xfer_cnt < 2 && n < 500) begin @(negedge wb_clk_i); n++; end
      ready_en = 1'b0;
      repeat (3) @(negedge wb_clk_i);
      #2;
      chk("ready low cyc", bus.wbs_cyc, 0);
      ready_en = 1'b1;
      wait_state("ready toggle", S_END);
      check_job("ready toggle", 6, 1, 16'd0, 1'b1);

      // Retry on the second data beat.
      mem.delete();
      put_desc(29'h100, 29'h6000, 16'd4, 1'b1, 29'h0);
      rty_at = 2;
      start_job(29'h100, 100);
      wait_state("rty", S_END);
      chk("rty seen", rty_cnt, 1);
      check_job("rty", 4, 1, 16'd0, 1'b1);
      rty_at = -1;

      // Reset in the middle of a buffer.
      mem.delete();
      put_desc(29'h100, 29'h5000, 16'd20, 1'b1, 29'h0);
      start_job(29'h100, 100);
      n = 0;
      while (xfer_cnt < 3 && n < 500) begin @(negedge wb_clk_i); n++; end
      chk("mid-burst reached", xfer_cnt >= 3, 1);
      wb_rst_i = 1'b0;
      @(negedge wb_clk_i);
      #2;
      saved = xfer_cnt;
      chk("mid rst cyc", bus.wbs_cyc, 0);
      chk("mid rst state", sg_state, 0);
      repeat (3) @(negedge wb_clk_i);
      #2;
      chk("mid rst no pop", xfer_cnt, saved);
      wb_rst_i = 1'b1;

      // Bus error while fetching a descriptor.
      mem.delete();
      put_desc(29'h100, 29'h5000, 16'd4, 1'b1, 29'h0);
      err_dreq = 1'b1;
      start_job(29'h100, 100);
      wait_state("err", S_PANIC);
      chk("err code", sg_err, S_D_REQ);
      chk("err cyc", bus.wbs_cyc, 0);
      chk("err no xfer", xfer_cnt, 0);
      err_dreq = 1'b0;
      repeat (5) @(negedge wb_clk_i);
      #2;
      chk("err sticky", sg_state[3:0], S_PANIC);
      wb_rst_i = 1'b0;
      repeat (2) @(negedge wb_clk_i);
      #2;
      chk("err reset state", sg_state, 0);
      outs_or = |{bus.wbs_cyc, bus.wbs_stb, bus.wbs_we, bus.wbs_cab, bus.wbs_sel, bus.wbs_adr,
                  bus.wbs_dat_i, bus.wbs_dat64_i, ss_xfer, sg_desc, sg_addr, sg_next, sg_err};
      chk("err reset outputs", outs_or, 0);
      wb_rst_i = 1'b1;

      // Random chains with random FIFO availability and retries.
      for (int it = 0; it < 8; it++) begin
         int nd = $urandom_range(1, 3);
         mem.delete();
         for (int d = 0; d < nd; d++)
            put_desc(29'(32'h100 + 2 * d), 29'(32'h8000 + 32'h100 * d), 16'($urandom_range(0, 6)),
                     (d == nd - 1) ? 1'b1 : ($urandom_range(0, 4) == 0),
                     29'(32'h100 + 2 * (d + 1)));
         ready_rand = 1'b1;
         rand_rty = 1'b1;
         start_job(29'h100, $urandom_range(1, 15));
         wait_state($sformatf("rnd%0d", it), S_END);
         ready_rand = 1'b0;
         rand_rty = 1'b0;
         ready_en = 1'b1;
         check_job($sformatf("rnd%0d", it), m_beats, m_wbs, m_len, m_last);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
